simd_eu_arbiter: RTL

- Shares one SIMD execution unit between N_REQ reservation-station requesters.
- Round-robin grant into a registered issue slot; allocates an internal tag per issued op; tracks up to MAX_INFLIGHT outstanding ops.
- Routes each EU result back to the owning requester with its original entry index.
- Sits between the issue stage and the SIMD EU; flush aborts everything in flight.

---
 rtl/simd_eu_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/simd_eu_arbiter.sv
// Round-robin arbiter sharing one SIMD execution unit between N_REQ requesters, with tag-based result routing.
// Optional SIMD_ARB_PERF_EN adds 32-bit issue and stall counters.
module simd_eu_arbiter #(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned EU_CTL_LEN   = 4,
    parameter int unsigned EXCEPT_LEN   = 2,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        flush_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*EU_CTL_LEN-1:0] req_ctl_i,
    input  logic [N_REQ*XLEN-1:0]       req_rs1_i,
    input  logic [N_REQ*XLEN-1:0]       req_rs2_i,
    input  logic [N_REQ*IDX_W-1:0]      req_idx_i,
    output logic                        eu_valid_o,
    input  logic                        eu_ready_i,
    output logic [EU_CTL_LEN-1:0]       eu_ctl_o,
    output logic [XLEN-1:0]             eu_rs1_o,
    output logic [XLEN-1:0]             eu_rs2_o,
    output logic [IDX_W-1:0]            eu_entry_idx_o,
    input  logic                        eu_valid_i,
    output logic                        eu_ready_o,
    input  logic [IDX_W-1:0]            eu_entry_idx_i,
    input  logic [XLEN-1:0]             eu_result_i,
    input  logic                        eu_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]       eu_except_code_i,
    output logic [N_REQ-1:0]            rsp_valid_o,
    input  logic [N_REQ-1:0]            rsp_ready_i,
    output logic [IDX_W-1:0]           rsp_idx_o,
    output logic [XLEN-1:0]             rsp_result_o,
    output logic                        rsp_except_raised_o,
    output logic [EXCEPT_LEN-1:0]       rsp_except_code_o
`ifdef SIMD_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_issue_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o
`endif
);

    localparam int unsigned TAG_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [MAX_INFLIGHT-1:0] busy;
    logic [OW-1:0]           owner   [MAX_INFLIGHT];
    logic [IDX_W-1:0]        idx_tbl [MAX_INFLIGHT];
    logic [OW-1:0]           rr_ptr;

    logic [OW-1:0]    win;
    logic [OW-1:0]    cand;
    logic             win_found;
    logic [TAG_W-1:0] free_tag;
    logic             free_found;
    logic             grant;
    logic             slot_free;
    logic             rsp_take;
    logic             res_accept;
    logic [TAG_W-1:0] rtag;
    logic             unused_idx;

    // Winner search from rr_ptr upward with wrap; lowest free tag.
    always_comb begin
        win        = '0;
        cand       = '0;
        win_found  = 1'b0;
        free_tag   = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = OW'((int'(rr_ptr) + i) % int'(N_REQ));
            if (!win_found && req_valid_i[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
        for (int t = int'(MAX_INFLIGHT) - 1; t >= 0; t--) begin
            if (!busy[t]) begin
                free_tag   = TAG_W'(t);
                free_found = 1'b1;
            end
        end
    end

    assign slot_free  = !eu_valid_o || eu_ready_i;
    assign grant      = rst_n_i && !flush_i && slot_free && free_found && win_found;
    assign rsp_take   = |(rsp_valid_o & rsp_ready_i);
    assign eu_ready_o = rst_n_i && (flush_i || !(|rsp_valid_o) || rsp_take);
    assign res_accept = eu_valid_i && eu_ready_o;
    assign rtag       = eu_entry_idx_i[TAG_W-1:0];
    assign unused_idx = ^eu_entry_idx_i;

    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < int'(N_REQ); r++) begin
            req_ready_o[r] = grant && (int'(win) == r);
        end
    end

    // Issue slot, tag table and response register; flush mirrors reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy                <= '0;
            rr_ptr              <= '0;
            eu_valid_o          <= 1'b0;
            eu_ctl_o            <= '0;
            eu_rs1_o            <= '0;
            eu_rs2_o            <= '0;
            eu_entry_idx_o      <= '0;
            rsp_valid_o         <= '0;
            rsp_idx_o           <= '0;
            rsp_result_o        <= '0;
            rsp_except_raised_o <= 1'b0;
            rsp_except_code_o   <= '0;
            for (int t = 0; t < int'(MAX_INFLIGHT); t++) begin
                owner[t]   <= '0;
                idx_tbl[t] <= '0;
            end
        end else if (flush_i) begin
            busy                <= '0;
            rr_ptr              <= '0;
            eu_valid_o          <= 1'b0;
            eu_ctl_o            <= '0;
            eu_rs1_o            <= '0;
            eu_rs2_o            <= '0;
            eu_entry_idx_o      <= '0;
            rsp_valid_o         <= '0;
            rsp_idx_o           <= '0;
            rsp_result_o        <= '0;
            rsp_except_raised_o <= 1'b0;
            rsp_except_code_o   <= '0;
            for (int t = 0; t < int'(MAX_INFLIGHT); t++) begin
                owner[t]   <= '0;
                idx_tbl[t] <= '0;
            end
        end else begin
            if (grant) begin
                eu_valid_o        <= 1'b1;
                eu_ctl_o          <= req_ctl_i[int'(win)*int'(EU_CTL_LEN) +: EU_CTL_LEN];
                eu_rs1_o          <= req_rs1_i[int'(win)*int'(XLEN) +: XLEN];
                eu_rs2_o          <= req_rs2_i[int'(win)*int'(XLEN) +: XLEN];
                eu_entry_idx_o    <= IDX_W'(free_tag);
                busy[free_tag]    <= 1'b1;
                owner[free_tag]   <= win;
                idx_tbl[free_tag] <= req_idx_i[int'(win)*int'(IDX_W) +: IDX_W];
                rr_ptr            <= (int'(win) == int'(N_REQ) - 1) ? '0 : win + OW'(1);
            end else if (eu_valid_o && eu_ready_i) begin
                eu_valid_o <= 1'b0;
            end

            // Stale tags (busy clear) are consumed without producing a response.
            if (res_accept && busy[rtag]) begin
                rsp_valid_o         <= N_REQ'(1) << owner[rtag];
                rsp_idx_o           <= idx_tbl[rtag];
                rsp_result_o        <= eu_result_i;
                rsp_except_raised_o <= eu_except_raised_i;
                rsp_except_code_o   <= eu_except_code_i;
                busy[rtag]          <= 1'b0;
            end else if (rsp_take) begin
                rsp_valid_o <= '0;
            end
        end
    end

`ifdef SIMD_ARB_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_issue_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (eu_valid_o && eu_ready_i) begin
                perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            end
            if ((|req_valid_i) && !grant) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
